// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep sequencer for the shared AND/NOT gate datapath: drives all four
// operand pairs, checks the returned results after a settle time and reports a verdict.

module gate_sweep_ctrl_chk (
  input logic       clk,
  input logic       rst,
  input logic       state_idle,
  input logic       state_check,
  input logic       state_done,
  input logic       busy,
  input logic       log_valid,
  input logic       done,
  input logic       op_a,
  input logic       op_b,
  input logic [1:0] vec_idx
);

  a_busy_tracks_state : assert property (@(posedge clk) disable iff (!rst) busy == !state_idle);
  a_log_in_check      : assert property (@(posedge clk) disable iff (!rst) log_valid == state_check);
  a_done_in_done      : assert property (@(posedge clk) disable iff (!rst) done == state_done);
  a_idx_matches_ops   : assert property (@(posedge clk) disable iff (!rst) vec_idx == {op_a, op_b});
  a_no_log_with_done  : assert property (@(posedge clk) disable iff (!rst) !(done && log_valid));

endmodule

module gate_sweep_ctrl #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned REPEAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       op_a,
  output logic       op_b,
  input  logic       res_and,
  input  logic       res_not,
  output logic       busy,
  output logic       log_valid,
  output logic [1:0] vec_idx,
  output logic [7:0] err_count,
  output logic       done,
  output logic       pass
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [7:0] SWEEP_LAST  = 8'(REPEAT - 1);

  // One vector counts once even when both returned results are wrong.
  function automatic logic vec_mismatch(input logic a, input logic b,
                                        input logic r_and, input logic r_not);
    return (r_and != (a & b)) || (r_not != ~a);
  endfunction

  state_t      state_r;
  state_t      next_state_s;
  logic [3:0]  settle_cnt_r;
  logic [7:0]  sweep_r;
  logic [7:0]  sweep_next_s;
  logic [7:0]  err_count_r;
  logic [7:0]  err_next_s;
  logic [1:0]  vec_idx_r;
  logic [1:0]  vec_next_s;
  logic        op_a_r;
  logic        op_b_r;
  logic        busy_r;
  logic        log_valid_r;
  logic        done_r;
  logic        pass_r;

  // Next-state, next vector, sweep and error-count decisions.
  always_comb begin
    next_state_s = state_r;
    err_next_s   = err_count_r;
    vec_next_s   = vec_idx_r;
    sweep_next_s = sweep_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_DRIVE;
          err_next_s   = 8'd0;
          vec_next_s   = 2'd0;
          sweep_next_s = 8'd0;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        next_state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (settle_cnt_r == 4'd0) begin
          next_state_s = ST_CHECK;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_CHECK: begin
        if (vec_mismatch(op_a_r, op_b_r, res_and, res_not) && (err_count_r != 8'hFF)) begin
          err_next_s = err_count_r + 8'd1;
        end else begin
          err_next_s = err_count_r;
        end
        if (vec_idx_r != 2'd3) begin
          vec_next_s   = vec_idx_r + 2'd1;
          next_state_s = ST_DRIVE;
        end else if (sweep_r != SWEEP_LAST) begin
          sweep_next_s = sweep_r + 8'd1;
          vec_next_s   = 2'd0;
          next_state_s = ST_DRIVE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; flags are decoded from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= 4'd0;
      sweep_r      <= 8'd0;
      err_count_r  <= 8'd0;
      vec_idx_r    <= 2'd0;
      op_a_r       <= 1'b0;
      op_b_r       <= 1'b0;
      busy_r       <= 1'b0;
      log_valid_r  <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      sweep_r     <= sweep_next_s;
      err_count_r <= err_next_s;
      vec_idx_r   <= vec_next_s;
      op_a_r      <= vec_next_s[1];
      op_b_r      <= vec_next_s[0];
      busy_r      <= (next_state_s != ST_IDLE);
      log_valid_r <= (next_state_s == ST_CHECK);
      done_r      <= (next_state_s == ST_DONE);
      if (state_r == ST_DRIVE) begin
        settle_cnt_r <= SETTLE_LOAD;
      end else if ((state_r == ST_WAIT) && (settle_cnt_r != 4'd0)) begin
        settle_cnt_r <= settle_cnt_r - 4'd1;
      end else begin
        settle_cnt_r <= settle_cnt_r;
      end
      // Verdict is valid alongside the done pulse and held until the next start.
      if ((state_r == ST_IDLE) && start) begin
        pass_r <= 1'b0;
      end else if (next_state_s == ST_DONE) begin
        pass_r <= (err_next_s == 8'd0);
      end else begin
        pass_r <= pass_r;
      end
    end
  end

  assign op_a      = op_a_r;
  assign op_b      = op_b_r;
  assign busy      = busy_r;
  assign log_valid = log_valid_r;
  assign vec_idx   = vec_idx_r;
  assign err_count = err_count_r;
  assign done      = done_r;
  assign pass      = pass_r;

  gate_sweep_ctrl_chk u_chk (
    .clk         (clk),
    .rst         (rst),
    .state_idle  (state_r == ST_IDLE),
    .state_check (state_r == ST_CHECK),
    .state_done  (state_r == ST_DONE),
    .busy        (busy_r),
    .log_valid   (log_valid_r),
    .done        (done_r),
    .op_a        (op_a_r),
    .op_b        (op_b_r),
    .vec_idx     (vec_idx_r)
  );

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboard bench for gate_sweep_ctrl: three parameterisations driven by an emulated
// datapath with selectable faults; expected log/done events are queued at start.

module tb_gate_sweep_ctrl;

  localparam int M_IDEAL = 0;
  localparam int M_AND1  = 1;
  localparam int M_NOT0  = 2;
  localparam int M_INV   = 3;

  typedef struct {
    int         inst;
    bit         is_done;
    int         cyc;
    logic [1:0] idx;
    logic [7:0] err;
    bit         pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] start_v = 3'b000;
  logic [2:0] op_a_v, op_b_v, res_and_v, res_not_v;
  logic [2:0] busy_v, log_v, done_v, pass_v;
  logic [1:0] vec_v [3];
  logic [7:0] err_v [3];
  int         mode_v [3] = '{0, 0, 0};
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  exp_t       sb [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic dp_and(input int mode, input logic a, input logic b);
    case (mode)
      M_AND1:  return 1'b1;
      M_INV:   return ~(a & b);
      default: return a & b;
    endcase
  endfunction

  function automatic logic dp_not(input int mode, input logic a);
    case (mode)
      M_NOT0:  return 1'b0;
      M_INV:   return a;
      default: return ~a;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dp
    assign res_and_v[g] = dp_and(mode_v[g], op_a_v[g], op_b_v[g]);
    assign res_not_v[g] = dp_not(mode_v[g], op_a_v[g]);
  end

  gate_sweep_ctrl #(.SETTLE(2), .REPEAT(1)) u_dut_def (
    .clk(clk), .rst(rst), .start(start_v[0]), .op_a(op_a_v[0]), .op_b(op_b_v[0]),
    .res_and(res_and_v[0]), .res_not(res_not_v[0]), .busy(busy_v[0]),
    .log_valid(log_v[0]), .vec_idx(vec_v[0]), .err_count(err_v[0]),
    .done(done_v[0]), .pass(pass_v[0])
  );

  gate_sweep_ctrl #(.SETTLE(1), .REPEAT(2)) u_dut_r2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .op_a(op_a_v[1]), .op_b(op_b_v[1]),
    .res_and(res_and_v[1]), .res_not(res_not_v[1]), .busy(busy_v[1]),
    .log_valid(log_v[1]), .vec_idx(vec_v[1]), .err_count(err_v[1]),
    .done(done_v[1]), .pass(pass_v[1])
  );

  gate_sweep_ctrl #(.SETTLE(2), .REPEAT(70)) u_dut_sat (
    .clk(clk), .rst(rst), .start(start_v[2]), .op_a(op_a_v[2]), .op_b(op_b_v[2]),
    .res_and(res_and_v[2]), .res_not(res_not_v[2]), .busy(busy_v[2]),
    .log_valid(log_v[2]), .vec_idx(vec_v[2]), .err_count(err_v[2]),
    .done(done_v[2]), .pass(pass_v[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc + 1);
    end
  endtask

  // Expected events for one run, using the spec's view of a correct/incorrect vector.
  task automatic push_run(input int inst, input int settle, input int rep, input int mode, input int t);
    int   err = 0;
    int   per = settle + 2;
    logic a, b;
    for (int s = 0; s < rep; s++) begin
      for (int v = 0; v < 4; v++) begin
        a = (v >= 2);
        b = (v % 2 == 1);
        sb.push_back('{inst, 1'b0, t + settle + 2 + (s * 4 + v) * per, 2'(v), 8'd0, 1'b0});
        if ((dp_and(mode, a, b) != (a & b)) || (dp_not(mode, a) != ~a)) begin
          if (err < 255) err++;
        end
      end
    end
    sb.push_back('{inst, 1'b1, t + 1 + 4 * rep * per, 2'd0, 8'(err), (err == 0)});
  endtask

  task automatic observe(input int inst, input logic lv, input logic dn,
                         input logic [1:0] idx, input logic [7:0] err, input logic ps);
    exp_t e;
    if ((lv === 1'b1) || (dn === 1'b1)) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_event", {inst[7:0], 6'd0, lv, dn}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("evt_inst", inst, e.inst);
        check_eq("evt_kind", {lv, dn}, e.is_done ? 2'b01 : 2'b10);
        check_eq("evt_cycle", cyc + 1, e.cyc);
        if (e.is_done) begin
          check_eq("done_err_count", err, e.err);
          check_eq("done_pass", ps, e.pass);
        end else begin
          check_eq("log_vec_idx", idx, e.idx);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) observe(i, log_v[i], done_v[i], vec_v[i], err_v[i], pass_v[i]);
  end

  task automatic drive_start(input int inst, output int t);
    @(negedge clk);
    start_v[inst] = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    start_v[inst] = 1'b0;
  endtask

  task automatic wait_done(input int inst, input int budget);
    int n = 0;
    while ((done_v[inst] !== 1'b1) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", done_v[inst], 1'b1);
  endtask

  task automatic run_std(input int inst, input int settle, input int rep, input int mode,
                         input int exp_err, input int budget, input bit extra_start);
    int t;
    mode_v[inst] = mode;
    drive_start(inst, t);
    push_run(inst, settle, rep, mode, t);
    check_eq("busy_in_drive", busy_v[inst], 1'b1);
    if (extra_start) begin
      while (cyc < t + 4) @(negedge clk);
      start_v[inst] = 1'b1;
      @(negedge clk);
      start_v[inst] = 1'b0;
    end
    wait_done(inst, budget);
    check_eq("final_err_count", err_v[inst], exp_err);
    check_eq("final_pass", pass_v[inst], (exp_err == 0));
    @(negedge clk);
    check_eq("busy_after_done", busy_v[inst], 1'b0);
    repeat (3) @(negedge clk);
    check_eq("pass_held", pass_v[inst], (exp_err == 0));
    check_eq("err_held", err_v[inst], exp_err);
  endtask

  initial begin
    int t;
    // Reset held with start asserted.
    start_v[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_op_a", op_a_v[0], 1'b0);
    check_eq("rst_op_b", op_b_v[0], 1'b0);
    check_eq("rst_busy", busy_v[0], 1'b0);
    check_eq("rst_done", done_v[0], 1'b0);
    check_eq("rst_log_valid", log_v[0], 1'b0);
    check_eq("rst_pass", pass_v[0], 1'b0);
    check_eq("rst_err_count", err_v[0], 8'd0);
    check_eq("rst_vec_idx", vec_v[0], 2'd0);
    rst = 1'b1;
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);

    run_std(0, 2, 1, M_IDEAL, 0, 40, 1'b0);
    run_std(0, 2, 1, M_AND1, 3, 40, 1'b0);
    run_std(0, 2, 1, M_IDEAL, 0, 40, 1'b1);

    // Reset in the middle of a sweep.
    mode_v[0] = M_IDEAL;
    drive_start(0, t);
    sb.push_back('{0, 1'b0, t + 4, 2'd0, 8'd0, 1'b0});
    while (cyc < t + 5) @(negedge clk);
    check_eq("busy_before_rst", busy_v[0], 1'b1);
    check_eq("op_b_before_rst", op_b_v[0], 1'b1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_eq("midrst_busy", busy_v[0], 1'b0);
    check_eq("midrst_op_a", op_a_v[0], 1'b0);
    check_eq("midrst_op_b", op_b_v[0], 1'b0);
    check_eq("midrst_vec_idx", vec_v[0], 2'd0);
    repeat (25) @(negedge clk);
    check_eq("midrst_no_pending", sb.size(), 0);
    run_std(0, 2, 1, M_IDEAL, 0, 40, 1'b0);

    run_std(1, 1, 2, M_NOT0, 4, 60, 1'b0);
    run_std(2, 2, 70, M_INV, 255, 1300, 1'b0);

    check_eq("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
